// File: rtl/seq_mult_ctrl_if.sv
// Handshake and data bundle for the sequential multiplier: operand request
// side (start/sgn/da/db/in_ready) and product delivery side
// (p/out_valid/out_ready).
interface seq_mult_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic                   sgn;
    logic [WIDTH-1:0]       da;
    logic [WIDTH-1:0]       db;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     p;

    // Operand source and product consumer
    modport master (
        output start, sgn, da, db, out_ready,
        input  in_ready, out_valid, p
    );

    // Multiplier
    modport slave (
        input  start, sgn, da, db, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Shift-add sequential multiplier with its own controller.
// One request is accepted in IDLE, WIDTH add/shift iterations follow, the
// sign is applied in a single fix-up cycle, and the product is held in a
// register until the consumer takes it. Signed mode multiplies magnitudes
// and negates the 2*WIDTH-bit result when the operand signs differ.
module seq_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    seq_mult_ctrl_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_p;
    logic [CW-1:0]          r_cnt;
    logic                   r_neg;
    logic                   r_valid;

    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [WIDTH:0]         w_sum;
    logic                   w_last;

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, which read as
    // unsigned is exactly its magnitude, so no extra bit is needed.
    always_comb begin
        w_mag_a = bus.da;
        w_mag_b = bus.db;
        if (bus.sgn && bus.da[WIDTH-1]) w_mag_a = -bus.da;
        if (bus.sgn && bus.db[WIDTH-1]) w_mag_b = -bus.db;
    end

    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode: fixed-length run, single fix-up, hold until taken
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)     w_next = S_RUN;
            S_RUN:   if (w_last)        w_next = S_FIX;
            S_FIX:                      w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, add/shift iterations, sign fix-up, result hold
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_p     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= w_mag_a;
                        r_b   <= w_mag_b;
                        r_neg <= bus.sgn & (bus.da[WIDTH-1] ^ bus.db[WIDTH-1]);
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    // carry of the partial sum enters the accumulator MSB
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_p     <= r_neg ? -r_acc : r_acc;
                    r_valid <= 1'b1;
                end
                S_DONE: begin
                    if (bus.out_ready) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_valid;
    assign bus.p         = r_p;
endmodule
